opb_register_bank_ppc2simulink: RTL and testbench

Parametrised OPB slave that presents `C_NUM_REGS` software-writable 32-bit registers to Simulink user logic. It generalises the single-register ppc2simulink block with byte-enable writes, per-register update strobes, full readback, and an optional double-buffered mode in which software stages all registers and then commits them to the fabric atomically. It sits on the PPC OPB bus in the XPS base system, one instance per yellow-block register group.

---
 rtl/opb_register_bank_ppc2simulink_pkg.sv | 18 +
 rtl/opb_register_bank_ppc2simulink_be_reg32.sv | 25 ++
 rtl/opb_register_bank_ppc2simulink.sv | 150 +++++++++++++++
 tb/tb_opb_register_bank_ppc2simulink.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/opb_register_bank_ppc2simulink_pkg.sv
// Shared definitions for the OPB register bank: FSM encoding, control
// register layout and the commit counter width.
package opb_regbank_defs;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    localparam int COMMIT_BIT = 31;
    localparam int CNT_W      = 16;

    // The control register sits immediately after the last user register.
    function automatic int ctrl_offset(input int num_regs);
        return num_regs;
    endfunction

endpackage

// File: rtl/opb_register_bank_ppc2simulink_be_reg32.sv
// 32-bit register with per-byte load enables and synchronous reset to a
// parameterised value; be[3] covers bits 31:24.
module opb_be_reg32 #(
    parameter logic [31:0] RESET_VAL = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  be,
    input  logic [31:0] d,
    output logic [31:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VAL;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) q[8*b +: 8] <= d[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave exposing C_NUM_REGS software-writable registers to fabric logic,
// with optional shadow staging and atomic commit via a control register.
module opb_register_bank_ppc2simulink
    import opb_regbank_defs::*;
#(
    parameter logic [31:0] C_BASEADDR      = 32'h0100_3300,
    parameter logic [31:0] C_HIGHADDR      = 32'h0100_33FF,
    parameter int          C_OPB_AWIDTH    = 32,
    parameter int          C_OPB_DWIDTH    = 32,
    parameter int          C_NUM_REGS      = 4,
    parameter int          C_DOUBLE_BUFFER = 1,
    parameter logic [31:0] C_RESET_VAL     = 32'h0,
    parameter              C_FAMILY        = "virtex5"
) (
    input  logic                        OPB_Clk,
    input  logic                        OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]     OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1]   OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
    input  logic                        OPB_RNW,
    input  logic                        OPB_select,
    input  logic                        OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]     Sl_DBus,
    output logic                        Sl_xferAck,
    output logic                        Sl_errAck,
    output logic                        Sl_retry,
    output logic                        Sl_toutSup,
    output logic [32*C_NUM_REGS-1:0]    user_data_out,
    output logic [C_NUM_REGS-1:0]       user_update
);

    state_t             state, state_nxt;
    logic [31:0]        addr, offset, wdata, rd_mux, rd_q;
    logic [3:0]         be;
    logic [7:0]         word;
    logic               hit, xfer_start, reg_wr, ctrl_wr, commit_fire;
    logic [CNT_W-1:0]   commit_count, commit_count_nxt;
    logic [C_NUM_REGS-1:0] upd_nxt;
    logic [31:0]        shadow [C_NUM_REGS];
    logic [31:0]        active [C_NUM_REGS];
    logic               unused_ok;

    // Big-endian bus vectors map MSB-to-MSB, so DBus[0] lands on wdata[31].
    assign addr  = OPB_ABus;
    assign wdata = OPB_DBus;
    assign be    = OPB_BE;

    // Word offset is taken relative to the window base so the base need not
    // be aligned beyond the window size.
    assign offset = addr - C_BASEADDR;
    assign word   = offset[9:2];
    assign hit    = OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);

    assign xfer_start  = (state == ST_IDLE) && hit;
    assign reg_wr      = xfer_start && !OPB_RNW && (word < 8'(C_NUM_REGS));
    assign ctrl_wr     = xfer_start && !OPB_RNW && (word == 8'(ctrl_offset(C_NUM_REGS)));
    assign commit_fire = ctrl_wr && wdata[COMMIT_BIT] && be[3];

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (hit) state_nxt = ST_ACK;
            ST_ACK:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < C_NUM_REGS; gi++) begin : g_reg
            logic [3:0] sh_be;
            assign sh_be = (reg_wr && word == 8'(gi)) ? be : 4'b0000;

            opb_be_reg32 #(.RESET_VAL(C_RESET_VAL)) u_shadow (
                .clk (OPB_Clk),
                .rst (OPB_Rst),
                .be  (sh_be),
                .d   (wdata),
                .q   (shadow[gi])
            );

            if (C_DOUBLE_BUFFER != 0) begin : g_active
                opb_be_reg32 #(.RESET_VAL(C_RESET_VAL)) u_active (
                    .clk (OPB_Clk),
                    .rst (OPB_Rst),
                    .be  ({4{commit_fire}}),
                    .d   (shadow[gi]),
                    .q   (active[gi])
                );
            end else begin : g_direct
                assign active[gi] = shadow[gi];
            end

            assign user_data_out[32*gi +: 32] = active[gi];
        end
    endgenerate

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (word == 8'(i)) rd_mux = shadow[i];
        end
        if (word == 8'(ctrl_offset(C_NUM_REGS)))
            rd_mux = {{(32-CNT_W){1'b0}}, commit_count};
    end

    always_comb begin
        upd_nxt = '0;
        if (C_DOUBLE_BUFFER != 0) begin
            if (commit_fire) upd_nxt = '1;
        end else begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                if (reg_wr && word == 8'(i)) upd_nxt[i] = 1'b1;
            end
        end
    end

    assign commit_count_nxt = ctrl_wr && commit_fire ? commit_count + 1'b1 : commit_count;

    // Read data is registered and cleared outside the ack cycle so the bus
    // OR-mux sees zero from this slave whenever it is not responding.
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            rd_q         <= '0;
            user_update  <= '0;
            commit_count <= '0;
        end else begin
            rd_q         <= (xfer_start && OPB_RNW) ? rd_mux : '0;
            user_update  <= upd_nxt;
            commit_count <= commit_count_nxt;
        end
    end

    assign Sl_DBus    = rd_q;
    assign Sl_xferAck = (state == ST_ACK);
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    assign unused_ok = &{1'b0, OPB_seqAddr, offset[31:10], offset[1:0],
                         (C_FAMILY == "virtex5")};

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Scoreboard bench: one direct-mode and one double-buffered bank; the driver
// queues expected ack responses and per-DUT monitors compare on each ack.
module tb_opb_register_bank_ppc2simulink;

    localparam logic [31:0]  BASE = 32'h0100_3300;
    localparam logic [31:0]  RV   = 32'hA5A5_0000;
    localparam logic [127:0] R4   = {RV, RV, RV, RV};

    typedef struct {
        bit           is_read;
        logic [31:0]  rd;
        logic [3:0]   upd;
        logic [127:0] out;
        string        name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [0:31]  d_abus, d_dbus, d_sl_dbus, b_abus, b_dbus, b_sl_dbus;
    logic [0:3]   d_be, b_be;
    logic         d_rnw, d_sel, d_ack, d_err, d_retry, d_tout;
    logic         b_rnw, b_sel, b_ack, b_err, b_retry, b_tout;
    logic [127:0] d_out, b_out;
    logic [3:0]   d_upd, b_upd;

    int   n_checks = 0;
    int   n_pass   = 0;
    bit   mon_en   = 1'b0;
    exp_t q_d[$];
    exp_t q_b[$];

    opb_register_bank_ppc2simulink #(
        .C_NUM_REGS(4), .C_DOUBLE_BUFFER(0), .C_RESET_VAL(RV)
    ) dut_d (
        .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(d_abus), .OPB_BE(d_be),
        .OPB_DBus(d_dbus), .OPB_RNW(d_rnw), .OPB_select(d_sel), .OPB_seqAddr(1'b0),
        .Sl_DBus(d_sl_dbus), .Sl_xferAck(d_ack), .Sl_errAck(d_err), .Sl_retry(d_retry),
        .Sl_toutSup(d_tout), .user_data_out(d_out), .user_update(d_upd)
    );

    opb_register_bank_ppc2simulink #(
        .C_NUM_REGS(4), .C_DOUBLE_BUFFER(1), .C_RESET_VAL(RV)
    ) dut_b (
        .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(b_abus), .OPB_BE(b_be),
        .OPB_DBus(b_dbus), .OPB_RNW(b_rnw), .OPB_select(b_sel), .OPB_seqAddr(1'b1),
        .Sl_DBus(b_sl_dbus), .Sl_xferAck(b_ack), .Sl_errAck(b_err), .Sl_retry(b_retry),
        .Sl_toutSup(b_tout), .user_data_out(b_out), .user_update(b_upd)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    task automatic mon(input bit use_b, input logic ack, input logic [31:0] rd,
                       input logic [3:0] upd, input logic [127:0] out, input logic [2:0] tied);
        exp_t  e;
        string tag;
        bit    empty;
        tag   = use_b ? "db" : "dir";
        empty = use_b ? (q_b.size() == 0) : (q_d.size() == 0);
        if (!ack) begin
            check({tag, "_idle_outputs_zero"}, {rd, upd, tied}, '0);
        end else if (empty) begin
            n_checks++;
            $display("FAIL %s_unexpected_ack: got ack=1, required no ack", tag);
        end else begin
            if (use_b) e = q_b.pop_front();
            else       e = q_d.pop_front();
            if (e.is_read) check({e.name, "_rdata"}, rd, e.rd);
            check({e.name, "_update"}, upd, e.upd);
            check({e.name, "_user_data"}, out, e.out);
            check({e.name, "_tied"}, tied, 3'b000);
        end
    endtask

    always @(negedge clk) if (mon_en) mon(1'b0, d_ack, d_sl_dbus, d_upd, d_out, {d_err, d_retry, d_tout});
    always @(negedge clk) if (mon_en) mon(1'b1, b_ack, b_sl_dbus, b_upd, b_out, {b_err, b_retry, b_tout});

    task automatic drive(input bit use_b, input logic sel, input logic rnw,
                         input logic [31:0] a, input logic [0:3] be, input logic [31:0] d);
        if (use_b) begin
            b_sel = sel; b_rnw = rnw; b_abus = a; b_be = be; b_dbus = d;
        end else begin
            d_sel = sel; d_rnw = rnw; d_abus = a; d_be = be; d_dbus = d;
        end
    endtask

    task automatic xfer(input bit use_b, input logic rnw, input logic [31:0] a,
                        input logic [0:3] be, input logic [31:0] d, input bit exp_ack,
                        input logic [31:0] exp_rd, input logic [3:0] exp_upd,
                        input logic [127:0] exp_out, input string name);
        exp_t e;
        bit   got;
        got = 1'b0;
        e.is_read = rnw; e.rd = exp_rd; e.upd = exp_upd; e.out = exp_out; e.name = name;
        if (exp_ack) begin
            if (use_b) q_b.push_back(e);
            else       q_d.push_back(e);
        end
        @(negedge clk);
        drive(use_b, 1'b1, rnw, a, be, d);
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk);
            #1;
            got = use_b ? b_ack : d_ack;
        end
        drive(use_b, 1'b0, 1'b0, '0, '0, '0);
        if (exp_ack && !got) begin
            n_checks++;
            $display("FAIL %s_timeout: got no ack in 8 cycles, required ack", name);
            if (use_b) void'(q_b.pop_back());
            else       void'(q_d.pop_back());
        end else if (!exp_ack) begin
            check({name, "_no_ack"}, 128'(got), 128'(0));
        end
    endtask

    function automatic logic [31:0] oa(input int off);
        return BASE + 32'(off) * 32'd4;
    endfunction

    task automatic wr(input bit use_b, input int off, input logic [0:3] be, input logic [31:0] d,
                      input logic [3:0] exp_upd, input logic [127:0] exp_out, input string name);
        xfer(use_b, 1'b0, oa(off), be, d, 1'b1, '0, exp_upd, exp_out, name);
    endtask

    task automatic rd(input bit use_b, input int off, input logic [31:0] exp_rd,
                      input logic [127:0] exp_out, input string name);
        xfer(use_b, 1'b1, oa(off), 4'b1111, '0, 1'b1, exp_rd, 4'b0000, exp_out, name);
    endtask

    localparam logic [127:0] D1 = {RV, 32'h1234_5678, RV, RV};
    localparam logic [127:0] D2 = {RV, 32'h1234_FF78, RV, RV};
    localparam logic [127:0] B1 = {32'h0000_0001, RV, RV, 32'hDEAD_BEEF};

    initial begin
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
        @(posedge clk);
        #1 mon_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_user_data_dir", d_out, R4);
        check("rst_user_data_db", b_out, R4);

        // Direct mode
        rd(1'b0, 4, 32'h0, R4, "dir_ctrl_after_rst");
        wr(1'b0, 2, 4'b1111, 32'h1234_5678, 4'b0100, D1, "dir_wr_full");
        wr(1'b0, 2, 4'b0010, 32'hFFFF_FFFF, 4'b0100, D2, "dir_wr_byte1");
        rd(1'b0, 2, 32'h1234_FF78, D2, "dir_rd_reg2");
        wr(1'b0, 4, 4'b1000, 32'h8000_0000, 4'b0000, D2, "dir_commit");
        rd(1'b0, 4, 32'h1, D2, "dir_ctrl_count1");
        rd(1'b0, 10, 32'h0, D2, "dir_rd_off10");
        wr(1'b0, 5, 4'b1111, 32'hFFFF_FFFF, 4'b0000, D2, "dir_wr_off5");
        rd(1'b0, 5, 32'h0, D2, "dir_rd_off5");
        xfer(1'b0, 1'b1, 32'h0100_3400, 4'b1111, '0, 1'b0, '0, '0, '0, "dir_miss");
        check("dir_miss_user_data", d_out, D2);

        // Double-buffered mode
        rd(1'b1, 4, 32'h0, R4, "db_ctrl_after_rst");
        wr(1'b1, 0, 4'b1111, 32'hDEAD_BEEF, 4'b0000, R4, "db_wr_reg0");
        wr(1'b1, 3, 4'b1111, 32'h0000_0001, 4'b0000, R4, "db_wr_reg3");
        rd(1'b1, 0, 32'hDEAD_BEEF, R4, "db_rd_shadow0");
        wr(1'b1, 0, 4'b0000, 32'h0000_0000, 4'b0000, R4, "db_wr_be0");
        rd(1'b1, 0, 32'hDEAD_BEEF, R4, "db_rd_after_be0");
        wr(1'b1, 4, 4'b1000, 32'h8000_0000, 4'b1111, B1, "db_commit");
        rd(1'b1, 4, 32'h1, B1, "db_ctrl_count1");
        wr(1'b1, 4, 4'b0111, 32'hFFFF_FFFF, 4'b0000, B1, "db_ctrl_no_be0");
        rd(1'b1, 4, 32'h1, B1, "db_ctrl_still1");

        // Counter wrap: preload the counter, then commit once
        @(negedge clk);
        force dut_b.commit_count_nxt = 16'hFFFF;
        @(posedge clk);
        #1 release dut_b.commit_count_nxt;
        rd(1'b1, 4, 32'h0000_FFFF, B1, "db_ctrl_ffff");
        wr(1'b1, 4, 4'b1000, 32'h8000_0000, 4'b1111, B1, "db_commit_wrap");
        rd(1'b1, 4, 32'h0, B1, "db_ctrl_wrapped");

        // Reset on the capture edge of a write: no ack, register untouched
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, oa(1), 4'b1111, 32'h5555_5555);
        rst = 1'b1;
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("db_rst_mid_user_data", b_out, R4);
        rd(1'b1, 1, RV, R4, "db_rst_mid_rd_reg1");

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 128'(q_d.size() + q_b.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
